// File: rtl/sap1_alu_accumulator_if.sv
// W-bus / control-word interface between the SAP-1 controller side and the
// accumulator + adder/subtractor stage.
interface sap1_alu_accumulator_if #(
  parameter int WIDTH = 8
);
  logic             nLa;
  logic             Ea;
  logic             Su;
  logic             Eu;
  logic [WIDTH-1:0] win;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] wout;
  logic             wen;
  logic [WIDTH-1:0] aout;
  logic             CF;
  logic             ZF;
  logic             NF;
  logic             VF;
  logic             bus_err;

  modport master (
    output nLa, Ea, Su, Eu, win, bin,
    input  wout, wen, aout, CF, ZF, NF, VF, bus_err
  );

  modport slave (
    input  nLa, Ea, Su, Eu, win, bin,
    output wout, wen, aout, CF, ZF, NF, VF, bus_err
  );
endinterface

// File: rtl/sap1_alu_accumulator.sv
// SAP-1 accumulator A with adder/subtractor, W-bus drive and latched flags.
// Define SAP1_ALU_OVF_EN to build the signed-overflow flag; otherwise VF is 0.
module sap1_alu_accumulator #(
  parameter int WIDTH = 8
) (
  input logic                   CLK,
  input logic                   CLR,
  sap1_alu_accumulator_if.slave bus
);

  logic [WIDTH-1:0] a_r;
  logic             cf_r;
  logic             zf_r;
  logic             nf_r;
  logic             bus_err_r;

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic [WIDTH-1:0] wout_s;
  logic             capture_s;
  logic             conflict_s;

  // Subtract is A + ~B + 1, so Carry=1 means no borrow.
  always_comb begin
    b_eff_s = bus.Su ? ~bus.bin : bus.bin;
    sum_s   = {1'b0, a_r} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, bus.Su};
    res_s   = sum_s[WIDTH-1:0];
    carry_s = sum_s[WIDTH];
  end

  // Bus drive mux; a conflicting request drives zero rather than either source.
  always_comb begin
    wout_s = {WIDTH{1'b0}};
    case ({bus.Ea, bus.Eu})
      2'b01:   wout_s = res_s;
      2'b10:   wout_s = a_r;
      default: wout_s = {WIDTH{1'b0}};
    endcase
  end

  assign capture_s  = bus.Eu & ~bus.Ea;
  assign conflict_s = bus.Eu & bus.Ea;

  // Accumulator, flag and sticky conflict registers.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      a_r       <= {WIDTH{1'b0}};
      cf_r      <= 1'b0;
      zf_r      <= 1'b0;
      nf_r      <= 1'b0;
      bus_err_r <= 1'b0;
    end else begin
      if (!bus.nLa) begin
        a_r <= bus.win;
      end
      if (capture_s) begin
        cf_r <= carry_s;
        zf_r <= (res_s == {WIDTH{1'b0}});
        nf_r <= res_s[WIDTH-1];
      end
      if (conflict_s) begin
        bus_err_r <= 1'b1;
      end
    end
  end

`ifdef SAP1_ALU_OVF_EN
  logic vf_r;
  logic ovf_s;

  // Signed overflow: operands share a sign and the result's sign differs.
  always_comb begin
    ovf_s = (a_r[WIDTH-1] == b_eff_s[WIDTH-1]) && (res_s[WIDTH-1] != a_r[WIDTH-1]);
  end

  // Overflow flag is captured alongside the other flags.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      vf_r <= 1'b0;
    end else if (capture_s) begin
      vf_r <= ovf_s;
    end
  end

  assign bus.VF = vf_r;
`else
  assign bus.VF = 1'b0;
`endif

  assign bus.wout    = wout_s;
  assign bus.wen     = bus.Ea | bus.Eu;
  assign bus.aout    = a_r;
  assign bus.CF      = cf_r;
  assign bus.ZF      = zf_r;
  assign bus.NF      = nf_r;
  assign bus.bus_err = bus_err_r;

endmodule

// File: tb/tb_sap1_alu_accumulator.sv
// Scoreboard bench for sap1_alu_accumulator: expected state is queued at drive
// time from an arithmetic reference model and popped after each clock edge.
module tb_sap1_alu_accumulator;

  logic CLK = 1'b0;
  logic CLR;
  always #5 CLK = ~CLK;

  sap1_alu_accumulator_if #(.WIDTH(8)) bus ();
  sap1_alu_accumulator #(.WIDTH(8)) dut (.CLK(CLK), .CLR(CLR), .bus(bus));

`ifdef SAP1_ALU_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic       cf, zf, nf, vf, err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  logic [7:0] m_a;
  logic       m_cf, m_zf, m_nf, m_vf, m_err;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic done with integers and signed range checks.
  task automatic model_alu(input logic [7:0] a, input logic [7:0] b, input logic su,
                           output logic [7:0] r, output logic c, output logic v);
    int ua, ub, ur, sa, sb, sr;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    if (su) begin
      ur = ua - ub; c = (ua >= ub); sr = sa - sb;
    end else begin
      ur = ua + ub; c = (ur > 255); sr = sa + sb;
    end
    r = ur[7:0];
    v = OVF_EN && ((sr > 127) || (sr < -128));
  endtask

  task automatic step(input logic clr, input logic nla, input logic ea, input logic su,
                      input logic eu, input logic [7:0] win, input logic [7:0] bin,
                      input logic mirror, input string tag);
    logic [7:0] r, exp_w;
    logic       c, v;
    exp_t       e, got;
    @(negedge CLK);
    model_alu(m_a, bin, su, r, c, v);
    if (eu && !ea)      exp_w = r;
    else if (ea && !eu) exp_w = m_a;
    else                exp_w = 8'h00;
    CLR = clr; bus.nLa = nla; bus.Ea = ea; bus.Su = su; bus.Eu = eu;
    bus.bin = bin;
    bus.win = mirror ? exp_w : win;
    #1;
    check({tag, "_wout"}, {8'h00, bus.wout}, {8'h00, exp_w});
    check({tag, "_wen"}, {15'h0, bus.wen}, {15'h0, ea | eu});
    if (clr) begin
      m_a = 8'h00; m_cf = 1'b0; m_zf = 1'b0; m_nf = 1'b0; m_vf = 1'b0; m_err = 1'b0;
    end else begin
      if (eu && !ea) begin
        m_cf = c; m_zf = (r == 8'h00); m_nf = r[7]; m_vf = v;
      end
      if (ea && eu) m_err = 1'b1;
      if (!nla) m_a = bus.win;
    end
    e.tag = tag; e.a = m_a; e.cf = m_cf; e.zf = m_zf; e.nf = m_nf; e.vf = m_vf; e.err = m_err;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    got = exp_q.pop_front();
    check({got.tag, "_aout"}, {8'h00, bus.aout}, {8'h00, got.a});
    check({got.tag, "_flags"}, {11'h0, bus.bus_err, bus.VF, bus.NF, bus.ZF, bus.CF},
          {11'h0, got.err, got.vf, got.nf, got.zf, got.cf});
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, tag);
  endtask

  task automatic load(input logic [7:0] v, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v, 8'h00, 1'b0, tag);
  endtask

  initial begin
    CLR = 1'b0; bus.nLa = 1'b1; bus.Ea = 1'b0; bus.Su = 1'b0; bus.Eu = 1'b0;
    bus.win = 8'h00; bus.bin = 8'h00;
    m_a = 8'h00; m_cf = 1'b0; m_zf = 1'b0; m_nf = 1'b0; m_vf = 1'b0; m_err = 1'b0;

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "rst0");
    // Dirty the state, then reset mid-writeback.
    load(8'h5A, "pre_ld");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, "pre_cf");
    check("pre_cf_lit", {15'h0, bus.CF}, 16'h0001);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, "pre_err");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 8'h01, 1'b0, "rst_mid");
    check("rst_aout_lit", {8'h00, bus.aout}, 16'h0000);
    check("rst_err_lit", {11'h0, bus.bus_err, bus.VF, bus.NF, bus.ZF, bus.CF}, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "rst_ea");
    check("rst_ea_wout_lit", {8'h00, bus.wout}, 16'h0000);

    load(8'h3C, "ld3c");
    check("ld3c_lit", {8'h00, bus.aout}, 16'h003C);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "drv3c");
    idle("idle0");
    check("idle_wen_lit", {15'h0, bus.wen}, 16'h0000);

    load(8'h07, "ld07");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h05, 1'b1, "add_wb");
    check("add_wb_lit", {8'h00, bus.aout}, 16'h000C);

    load(8'h05, "ld05");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 1'b0, "sub_zero");
    check("sub_zero_zc_lit", {14'h0, bus.ZF, bus.CF}, 16'h0003);
    load(8'h03, "ld03");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h05, 1'b0, "sub_borrow");
    check("sub_borrow_nc_lit", {14'h0, bus.NF, bus.CF}, 16'h0002);

    load(8'h7F, "ld7f");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, "ovf");
    check("ovf_vf_lit", {15'h0, bus.VF}, {15'h0, OVF_EN});
    load(8'hFF, "ldff");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 1'b0, "wrap");
    check("wrap_zc_lit", {14'h0, bus.ZF, bus.CF}, 16'h0003);

    load(8'h11, "ld11");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h22, 1'b0, "conflict");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, "su_only");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "ea_reload");

    for (int i = 0; i < 40; i++) begin
      logic nla, ea, eu, su, clr;
      nla = 1'($urandom_range(0, 1));
      ea  = ($urandom_range(0, 3) == 0);
      eu  = ($urandom_range(0, 1) == 1);
      su  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 15) == 0);
      step(clr, nla, ea, su, eu, 8'($urandom), 8'($urandom), eu & ~ea & ~nla, "rnd");
    end

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, "err_set");
    idle("err_hold");
    check("err_hold_lit", {15'h0, bus.bus_err}, 16'h0001);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "err_clr");
    check("err_clr_lit", {15'h0, bus.bus_err}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
